rvfi_commit_serializer: RTL and testbench

RVFI_COMMIT_SERIALIZER -- requirements
Module: rvfi_commit_serializer

---
 rtl/rvfi_commit_serializer_pkg.sv | 18 +
 rtl/rvfi_pkg.sv | 23 ++
 rtl/rvfi_commit_serializer_if.sv | 34 +++
 rtl/rvfi_commit_serializer_trace_fifo.sv | 65 ++++++
 rtl/rvfi_commit_serializer.sv | 121 ++++++++++++
 tb/tb_rvfi_commit_serializer.sv | 287 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/rvfi_commit_serializer_pkg.sv
// Constants and helpers local to the commit serializer.
// Latency: n/a (package).
// Backpressure: n/a (package).
package rvfi_commit_serializer_pkg;

    localparam int          DROP_CNT_W   = 16;
    localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;
    localparam int          ENTRY_W      = $bits(rvfi_pkg::rvfi_trace_entry_t);

    // Saturating add for the drop counter.
    function automatic logic [DROP_CNT_W-1:0] sat_add16(input logic [DROP_CNT_W-1:0] a,
                                                        input logic [DROP_CNT_W-1:0] b);
        logic [DROP_CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[DROP_CNT_W] ? DROP_CNT_MAX : sum[DROP_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/rvfi_pkg.sv
// RVFI record types shared by the commit serializer and its consumers.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package rvfi_pkg;

    // One retired (or trapped) instruction as reported by the core.
    typedef struct packed {
        logic        valid;
        logic        trap;
        logic [31:0] insn;
        logic [63:0] pc_rdata;
        logic [4:0]  rd_addr;
        logic [63:0] rd_wdata;
    } rvfi_instr_t;

    // One serialized trace entry: the record plus its capture-cycle and order stamps.
    typedef struct packed {
        rvfi_instr_t rec;
        logic [31:0] cycle;
        logic [63:0] order;
    } rvfi_trace_entry_t;

endpackage

// File: rtl/rvfi_commit_serializer_if.sv
// Signal bundle between a core/trace sink and the commit serializer.
// Latency: n/a (wiring only).
// Backpressure: trace_ready from the sink; trace side is valid/ready.
// Ports: rvfi/flush in from the core, trace_valid/trace_ready/trace toward the sink,
//        level/overflow/drop_cnt as status.
interface rvfi_commit_serializer_if
    import rvfi_pkg::*;
#(
    parameter int NR_COMMIT_PORTS = 2,
    parameter int DEPTH           = 8
) ();

    rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi;
    logic                              flush;
    logic                              trace_valid;
    logic                              trace_ready;
    rvfi_trace_entry_t                 trace;
    logic [$clog2(DEPTH):0]            level;
    logic                              overflow;
    logic [15:0]                       drop_cnt;

    // Core and sink side.
    modport master (
        output rvfi, flush, trace_ready,
        input  trace_valid, trace, level, overflow, drop_cnt
    );

    // Serializer side.
    modport slave (
        input  rvfi, flush, trace_ready,
        output trace_valid, trace, level, overflow, drop_cnt
    );

endinterface

// File: rtl/rvfi_commit_serializer_trace_fifo.sv
// Multi-write, single-read circular buffer holding serialized trace entries.
// Latency: a write is visible at rd_data_o/level_o one cycle later.
// Backpressure: none internally; the writer must not exceed free space.
// Ports: clk_i/rst_i, flush_i (sync clear), wr_cnt_i entries from wr_data_i[0..],
//        rd_en_i pops the head, rd_data_o head entry, level_o occupancy.
module rvfi_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int NR_WR = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(NR_WR + 1),
    localparam int LW   = AW + 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic [CW-1:0]               wr_cnt_i,
    input  logic [NR_WR-1:0][WIDTH-1:0] wr_data_i,
    input  logic                        rd_en_i,
    output logic [WIDTH-1:0]            rd_data_o,
    output logic [LW-1:0]               level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;

    // Pointers are exactly AW bits wide, so the additions wrap modulo DEPTH.
    always_comb begin
        wptr_d  = wptr_q + AW'(wr_cnt_i);
        rptr_d  = rptr_q + AW'(rd_en_i);
        level_d = level_q + LW'(wr_cnt_i) - LW'(rd_en_i);
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage is not reset; contents are only observed while level_q != 0.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NR_WR; k++) begin
            if (!flush_i && (k < int'(wr_cnt_i))) begin
                mem_q[wptr_q + AW'(k)] <= wr_data_i[k];
            end
        end
    end

    assign rd_data_o = mem_q[rptr_q];
    assign level_o   = level_q;

endmodule

// File: rtl/rvfi_commit_serializer.sv
// Serializes up to NR_COMMIT_PORTS RVFI commits per cycle into one stamped trace stream.
// Latency: one cycle from capture to trace_valid_o; all outputs are registered.
// Backpressure: trace_ready_i stalls the head; a cycle that does not fit is dropped whole and counted.
// Ports: clk_i/rst_i, rvfi_i commit records, flush_i buffer clear, trace_valid_o/trace_ready_i/trace_o
//        output stream, level_o occupancy, overflow_o sticky drop flag, drop_cnt_o saturating drop count.
module rvfi_commit_serializer
    import rvfi_pkg::*;
    import rvfi_commit_serializer_pkg::*;
#(
    parameter int NR_COMMIT_PORTS = 2,
    parameter int DEPTH           = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i,
    input  logic                              flush_i,
    output logic                              trace_valid_o,
    input  logic                              trace_ready_i,
    output rvfi_trace_entry_t                 trace_o,
    output logic [$clog2(DEPTH):0]            level_o,
    output logic                              overflow_o,
    output logic [15:0]                       drop_cnt_o
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(NR_COMMIT_PORTS + 1);

    logic [31:0]           cycle_q, cycle_d;
    logic [63:0]           order_q, order_d;
    logic                  overflow_q, overflow_d;
    logic [15:0]           drop_cnt_q, drop_cnt_d;

    logic [NR_COMMIT_PORTS-1:0] cap;
    logic [CW-1:0]              slot [NR_COMMIT_PORTS];
    logic [CW-1:0]              n_cap;
    logic [LW-1:0]              level;
    logic [LW-1:0]              free_slots;
    logic                       fits;
    logic                       accept;
    logic                       reject;
    logic                       pop;
    logic [CW-1:0]              wr_cnt;
    logic [NR_COMMIT_PORTS-1:0][ENTRY_W-1:0] wr_data;
    logic [ENTRY_W-1:0]         rd_data;

    // Each captured port's slot is the number of captured ports below it,
    // which packs captures densely in ascending port order.
    always_comb begin
        n_cap = '0;
        for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
            cap[i]  = rvfi_i[i].valid | rvfi_i[i].trap;
            slot[i] = n_cap;
            n_cap   = n_cap + CW'(cap[i]);
        end
    end

    always_comb begin
        wr_data = '0;
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            for (int i = 0; i < NR_COMMIT_PORTS; i++) begin
                if (cap[i] && (slot[i] == CW'(k))) begin
                    wr_data[k] = {rvfi_i[i], cycle_q, order_q + 64'(k)};
                end
            end
        end
    end

    // Room is judged against the pre-pop level: a same-cycle pop gives no credit.
    always_comb begin
        free_slots = LW'(DEPTH) - level;
        fits       = 32'(n_cap) <= 32'(free_slots);
        accept     = !flush_i && (n_cap != '0) && fits;
        reject     = !flush_i && (n_cap != '0) && !fits;
        wr_cnt     = accept ? n_cap : '0;
        pop        = trace_valid_o && trace_ready_i;
    end

    // Order advances for every captured entry, so drops and flushes leave gaps.
    always_comb begin
        cycle_d    = cycle_q + 32'd1;
        order_d    = order_q + 64'(n_cap);
        overflow_d = overflow_q | reject;
        drop_cnt_d = reject ? sat_add16(drop_cnt_q, 16'(n_cap)) : drop_cnt_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle_q    <= '0;
            order_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            cycle_q    <= cycle_d;
            order_q    <= order_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    rvfi_trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .NR_WR (NR_COMMIT_PORTS)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (flush_i),
        .wr_cnt_i  (wr_cnt),
        .wr_data_i (wr_data),
        .rd_en_i   (pop),
        .rd_data_o (rd_data),
        .level_o   (level)
    );

    assign trace_o       = rd_data;
    assign level_o       = level;
    assign trace_valid_o = (level != '0);
    assign overflow_o    = overflow_q;
    assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Self-checking bench for rvfi_commit_serializer: scoreboard of expected entries,
// table-driven vectors, and directed multi-cycle sequences.
// Latency/backpressure: exercised through the sequences below.
module tb_rvfi_commit_serializer;
    import rvfi_pkg::*;

    localparam int NR    = 2;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rvfi_commit_serializer_if #(.NR_COMMIT_PORTS(NR), .DEPTH(DEPTH)) bus ();

    rvfi_commit_serializer #(.NR_COMMIT_PORTS(NR), .DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rvfi_i        (bus.rvfi),
        .flush_i       (bus.flush),
        .trace_valid_o (bus.trace_valid),
        .trace_ready_i (bus.trace_ready),
        .trace_o       (bus.trace),
        .level_o       (bus.level),
        .overflow_o    (bus.overflow),
        .drop_cnt_o    (bus.drop_cnt)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    rvfi_trace_entry_t exp_q[$];
    logic [31:0]       m_cycle = '0;
    logic [63:0]       m_order = '0;
    logic              m_ovf   = 1'b0;
    logic [15:0]       m_drop  = '0;
    int                m_n;
    int                m_k;
    int                m_sum;
    logic              m_pop;
    rvfi_trace_entry_t m_e;

    rvfi_instr_t last_rec [NR];
    int          tag = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_entry(input string name, input rvfi_trace_entry_t act, input rvfi_trace_entry_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got order=%0d cycle=%0d insn=%h pc=%h expected order=%0d cycle=%0d insn=%h pc=%h (t=%0t)",
                     name, act.order, act.cycle, act.rec.insn, act.rec.pc_rdata,
                     exp.order, exp.cycle, exp.rec.insn, exp.rec.pc_rdata, $time);
        end
    endtask

    // Model: captures in port order, all-or-nothing against pre-pop occupancy.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_cycle = '0;
            m_order = '0;
            m_ovf   = 1'b0;
            m_drop  = '0;
        end else begin
            m_n = 0;
            for (int i = 0; i < NR; i++)
                if (bus.rvfi[i].valid || bus.rvfi[i].trap) m_n++;
            if (bus.flush) begin
                exp_q.delete();
            end else begin
                m_pop = (exp_q.size() != 0) && bus.trace_ready;
                if (m_n <= DEPTH - exp_q.size()) begin
                    m_k = 0;
                    for (int i = 0; i < NR; i++) begin
                        if (bus.rvfi[i].valid || bus.rvfi[i].trap) begin
                            m_e.rec   = bus.rvfi[i];
                            m_e.cycle = m_cycle;
                            m_e.order = m_order + 64'(m_k);
                            exp_q.push_back(m_e);
                            m_k++;
                        end
                    end
                end else begin
                    m_ovf  = 1'b1;
                    m_sum  = int'(m_drop) + m_n;
                    m_drop = (m_sum > 65535) ? 16'hFFFF : 16'(m_sum);
                end
                if (m_pop) void'(exp_q.pop_front());
            end
            m_order = m_order + 64'(m_n);
            m_cycle = m_cycle + 32'd1;
        end
    end

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("mon_level", 64'(bus.level), 64'(exp_q.size()));
            chk("mon_valid", 64'(bus.trace_valid), 64'(exp_q.size() != 0));
            chk("mon_overflow", 64'(bus.overflow), 64'(m_ovf));
            chk("mon_drop", 64'(bus.drop_cnt), 64'(m_drop));
            if (bus.trace_valid && exp_q.size() != 0) chk_entry("mon_head", bus.trace, exp_q[0]);
        end
    end

    // Drive one cycle of stimulus, then return 1 time unit after the edge.
    task automatic step(input logic [1:0] v, input logic [1:0] t, input logic rdy, input logic fl);
        rvfi_instr_t rec;
        for (int i = 0; i < NR; i++) begin
            tag++;
            rec          = '0;
            rec.valid    = v[i];
            rec.trap     = t[i];
            rec.insn     = (tag % 4 == 0) ? 32'h00000073 : $urandom;
            rec.pc_rdata = 64'h8000_0000 + 64'(tag) * 64'd4;
            rec.rd_addr  = 5'(tag);
            rec.rd_wdata = {$urandom, $urandom};
            bus.rvfi[i]  = rec;
            last_rec[i]  = rec;
        end
        bus.trace_ready = rdy;
        bus.flush       = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.rvfi        = '0;
        bus.flush       = 1'b0;
        bus.trace_ready = 1'b0;
        rst             = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0] v;
        logic [1:0] t;
        logic       rdy;
        logic       fl;
        int         lvl;
        logic       vld;
        logic       ovf;
        int         drop;
    } vec_t;

    vec_t tbl [14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rvfi_instr_t       p0, p1;
        rvfi_trace_entry_t e;

        bus.rvfi        = '0;
        bus.flush       = 1'b0;
        bus.trace_ready = 1'b0;

        tbl[0]  = '{2'b11, 2'b00, 1'b0, 1'b0, 2, 1'b1, 1'b0, 0};
        tbl[1]  = '{2'b01, 2'b00, 1'b0, 1'b0, 3, 1'b1, 1'b0, 0};
        tbl[2]  = '{2'b00, 2'b10, 1'b1, 1'b0, 3, 1'b1, 1'b0, 0};
        tbl[3]  = '{2'b11, 2'b00, 1'b1, 1'b0, 4, 1'b1, 1'b0, 0};
        tbl[4]  = '{2'b11, 2'b11, 1'b0, 1'b0, 6, 1'b1, 1'b0, 0};
        tbl[5]  = '{2'b00, 2'b00, 1'b1, 1'b0, 5, 1'b1, 1'b0, 0};
        tbl[6]  = '{2'b11, 2'b00, 1'b0, 1'b0, 7, 1'b1, 1'b0, 0};
        tbl[7]  = '{2'b11, 2'b00, 1'b0, 1'b0, 7, 1'b1, 1'b1, 2};
        tbl[8]  = '{2'b01, 2'b00, 1'b0, 1'b0, 8, 1'b1, 1'b1, 2};
        tbl[9]  = '{2'b10, 2'b00, 1'b1, 1'b0, 7, 1'b1, 1'b1, 3};
        tbl[10] = '{2'b11, 2'b00, 1'b1, 1'b1, 0, 1'b0, 1'b1, 3};
        tbl[11] = '{2'b00, 2'b00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 3};
        tbl[12] = '{2'b00, 2'b01, 1'b0, 1'b0, 1, 1'b1, 1'b1, 3};
        tbl[13] = '{2'b10, 2'b10, 1'b1, 1'b0, 1, 1'b1, 1'b1, 3};

        // Reset state while reset is held.
        #1;
        chk("rst_level", 64'(bus.level), 64'd0);
        chk("rst_valid", 64'(bus.trace_valid), 64'd0);
        chk("rst_overflow", 64'(bus.overflow), 64'd0);
        chk("rst_drop", 64'(bus.drop_cnt), 64'd0);

        // Two ports at cycle 5: port 0 then port 1, same cycle stamp, orders 0/1.
        do_reset();
        for (int c = 0; c < 5; c++) step(2'b00, 2'b00, 1'b1, 1'b0);
        chk("dual_valid_before", 64'(bus.trace_valid), 64'd0);
        step(2'b11, 2'b00, 1'b1, 1'b0);
        p0 = last_rec[0];
        p1 = last_rec[1];
        chk("dual_valid_after", 64'(bus.trace_valid), 64'd1);
        chk("dual_level", 64'(bus.level), 64'd2);
        e = '{rec: p0, cycle: 32'd5, order: 64'd0};
        chk_entry("dual_first", bus.trace, e);
        step(2'b00, 2'b00, 1'b1, 1'b0);
        e = '{rec: p1, cycle: 32'd5, order: 64'd1};
        chk_entry("dual_second", bus.trace, e);
        step(2'b00, 2'b00, 1'b1, 1'b0);
        chk("dual_drained", 64'(bus.level), 64'd0);

        // Only port 1 traps: single entry, no empty slot.
        do_reset();
        step(2'b00, 2'b10, 1'b1, 1'b0);
        p1 = last_rec[1];
        chk("trap1_level", 64'(bus.level), 64'd1);
        e = '{rec: p1, cycle: 32'd0, order: 64'd0};
        chk_entry("trap1_entry", bus.trace, e);
        step(2'b00, 2'b00, 1'b1, 1'b0);
        chk("trap1_drained", 64'(bus.level), 64'd0);

        // Fill with ready low, reject the fifth cycle, then check the order gap.
        do_reset();
        for (int c = 0; c < 4; c++) step(2'b11, 2'b00, 1'b0, 1'b0);
        chk("fill_level", 64'(bus.level), 64'd8);
        chk("fill_no_ovf", 64'(bus.overflow), 64'd0);
        step(2'b11, 2'b00, 1'b0, 1'b0);
        chk("fill_rej_level", 64'(bus.level), 64'd8);
        chk("fill_rej_ovf", 64'(bus.overflow), 64'd1);
        chk("fill_rej_drop", 64'(bus.drop_cnt), 64'd2);
        for (int c = 0; c < 8; c++) step(2'b00, 2'b00, 1'b1, 1'b0);
        chk("fill_drained", 64'(bus.level), 64'd0);
        step(2'b01, 2'b00, 1'b0, 1'b0);
        chk("fill_next_order", bus.trace.order, 64'd10);
        step(2'b00, 2'b00, 1'b1, 1'b0);

        // Level 7 with a pop: two captures still rejected.
        do_reset();
        for (int c = 0; c < 3; c++) step(2'b11, 2'b00, 1'b0, 1'b0);
        step(2'b01, 2'b00, 1'b0, 1'b0);
        chk("nocredit_pre", 64'(bus.level), 64'd7);
        step(2'b11, 2'b00, 1'b1, 1'b0);
        chk("nocredit_level", 64'(bus.level), 64'd6);
        chk("nocredit_drop", 64'(bus.drop_cnt), 64'd2);

        // Flush with a same-cycle capture at level 3.
        do_reset();
        step(2'b11, 2'b00, 1'b0, 1'b0);
        step(2'b01, 2'b00, 1'b0, 1'b0);
        chk("flush_pre", 64'(bus.level), 64'd3);
        step(2'b01, 2'b00, 1'b1, 1'b1);
        chk("flush_level", 64'(bus.level), 64'd0);
        chk("flush_valid", 64'(bus.trace_valid), 64'd0);
        chk("flush_drop", 64'(bus.drop_cnt), 64'd0);
        step(2'b01, 2'b00, 1'b0, 1'b0);
        chk("flush_order_gap", bus.trace.order, 64'd4);

        // Asynchronous reset mid-stream with level 5 and overflow set.
        do_reset();
        for (int c = 0; c < 5; c++) step(2'b11, 2'b00, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) step(2'b00, 2'b00, 1'b1, 1'b0);
        chk("arst_pre_level", 64'(bus.level), 64'd5);
        chk("arst_pre_ovf", 64'(bus.overflow), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_level", 64'(bus.level), 64'd0);
        chk("arst_valid", 64'(bus.trace_valid), 64'd0);
        chk("arst_ovf", 64'(bus.overflow), 64'd0);
        chk("arst_drop", 64'(bus.drop_cnt), 64'd0);

        // Table-driven vectors from an empty buffer.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].v, tbl[i].t, tbl[i].rdy, tbl[i].fl);
            chk($sformatf("vec%0d_level", i), 64'(bus.level), 64'(tbl[i].lvl));
            chk($sformatf("vec%0d_valid", i), 64'(bus.trace_valid), 64'(tbl[i].vld));
            chk($sformatf("vec%0d_ovf", i), 64'(bus.overflow), 64'(tbl[i].ovf));
            chk($sformatf("vec%0d_drop", i), 64'(bus.drop_cnt), 64'(tbl[i].drop));
        end
        for (int c = 0; c < 3; c++) step(2'b00, 2'b00, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
